mmio_uart_perf: RTL and testbench

- Parametrised successor to the core's unbuffered UART/counter MMIO path.
- Sits between the memory stage and the on-chip uart. Adds TX/RX FIFOs of configurable depth, N generic event counters, and a sticky overflow flag.
- Load data is returned one cycle after the request, which matches the memory/writeback timing.

---
 rtl/mmio_pkg.sv | 46 ++++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/mmio_uart_perf.sv | 167 ++++++++++++++++
 tb/tb_mmio_uart_perf.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// ============================================================================
// Module      : mmio_pkg
// Description : Address map and status-bit constants for the MMIO UART/counter block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam logic [11:0] ADDR_STATUS      = 12'h000;
    localparam logic [11:0] ADDR_RX_DATA     = 12'h004;
    localparam logic [11:0] ADDR_TX_DATA     = 12'h008;
    localparam logic [11:0] ADDR_LEVELS      = 12'h00C;
    localparam logic [11:0] ADDR_CNT_CLR     = 12'h010;
    localparam logic [11:0] ADDR_CNT_BASE    = 12'h100;

    localparam logic [11:0] ADDR_LEG_CNT0    = 12'h010;
    localparam logic [11:0] ADDR_LEG_CNT1    = 12'h014;
    localparam logic [11:0] ADDR_LEG_CNT_CLR = 12'h018;
    localparam logic [11:0] ADDR_LEG_CNT2    = 12'h01C;
    localparam logic [11:0] ADDR_LEG_CNT3    = 12'h020;

    // Never matches a word-aligned address.
    localparam logic [11:0] ADDR_NONE        = 12'hFFF;

    localparam int ST_TX_NOTFULL  = 0;
    localparam int ST_RX_NONEMPTY = 1;
    localparam int ST_TX_OVF      = 2;

    function automatic logic [11:0] cnt_addr(input int idx);
        return ADDR_CNT_BASE + 12'(4 * idx);
    endfunction

    function automatic logic [11:0] leg_cnt_addr(input int idx);
        case (idx)
            0:       return ADDR_LEG_CNT0;
            1:       return ADDR_LEG_CNT1;
            2:       return ADDR_LEG_CNT2;
            3:       return ADDR_LEG_CNT3;
            default: return ADDR_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through FIFO, 2**AW entries, with full/empty/level.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_MSB = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Full/empty come from the pre-cycle pointers, so a pop never frees room
    // for a push in the same cycle.
    assign full_o    = (wptr_q ^ rptr_q) == PTR_MSB;
    assign empty_o   = (wptr_q == rptr_q);
    assign level_o   = wptr_q - rptr_q;
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];
    assign w_push_ok = push_i && !full_o;
    assign w_pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_push_ok) wptr_d = wptr_q + (AW+1)'(1);
        if (w_pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_perf.sv
// ============================================================================
// Module      : mmio_uart_perf
// Description : MMIO bridge to the UART with TX/RX FIFOs, event counters and a
//               sticky TX-overflow flag. Define MMIO_LEGACY_MAP_EN for the
//               legacy counter aliases.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mmio_uart_perf
    import mmio_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [11:0]        req_addr,
    input  logic [7:0]         req_wdata,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic [NUM_CNT-1:0] cnt_event
);

    logic [11:0]      w_addr;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_unused_addr;

    logic             w_tx_push;
    logic             w_tx_drop;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [FIFO_AW:0] w_tx_level;

    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [7:0]       w_rx_head;
    logic [FIFO_AW:0] w_rx_level;

    logic             w_cnt_clr;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];

    logic             ovf_q, ovf_d;
    logic [31:0]      w_rdata;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q;

    assign w_addr        = {req_addr[11:2], 2'b00};
    assign w_unused_addr = ^req_addr[1:0];
    assign w_is_load     = req_valid && !req_we;
    assign w_is_store    = req_valid && req_we;

    assign w_tx_push = w_is_store && (w_addr == ADDR_TX_DATA);
    assign w_tx_drop = w_tx_push && w_tx_full;
    assign w_rx_pop  = w_is_load && (w_addr == ADDR_RX_DATA);
    assign w_rx_push = rx_valid && rx_ready;

`ifdef MMIO_LEGACY_MAP_EN
    assign w_cnt_clr = w_is_store &&
                       ((w_addr == ADDR_CNT_CLR) || (w_addr == ADDR_LEG_CNT_CLR));
`else
    assign w_cnt_clr = w_is_store && (w_addr == ADDR_CNT_CLR);
`endif

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_tx_push),
        .wdata_i (req_wdata),
        .pop_i   (tx_ready),
        .rdata_o (tx_data),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty),
        .level_o (w_tx_level)
    );

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_rx_push),
        .wdata_i (rx_data),
        .pop_i   (w_rx_pop),
        .rdata_o (w_rx_head),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty),
        .level_o (w_rx_level)
    );

    assign tx_valid = !w_tx_empty;
    // Held low while reset is asserted so the uart never sees a stale ready.
    assign rx_ready = rst_n && !w_rx_full;

    // Sticky overflow: a status read clears it, a same-cycle drop re-sets it.
    always_comb begin
        ovf_d = ovf_q;
        if (w_is_load && (w_addr == ADDR_STATUS)) ovf_d = 1'b0;
        if (w_tx_drop)                            ovf_d = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            if (w_cnt_clr)         cnt_d[i] = '0;
            else if (cnt_event[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else                   cnt_d[i] = cnt_q[i];
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_addr == ADDR_STATUS) begin
            w_rdata[ST_TX_NOTFULL]  = !w_tx_full;
            w_rdata[ST_RX_NONEMPTY] = !w_rx_empty;
            w_rdata[ST_TX_OVF]      = ovf_q;
        end else if (w_addr == ADDR_RX_DATA) begin
            w_rdata = {24'h0, (w_rx_empty ? 8'h00 : w_rx_head)};
        end else if (w_addr == ADDR_LEVELS) begin
            w_rdata = {16'h0, 8'(w_rx_level), 8'(w_tx_level)};
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (w_addr == cnt_addr(i)) w_rdata = 32'(cnt_q[i]);
`ifdef MMIO_LEGACY_MAP_EN
            if (w_addr == leg_cnt_addr(i)) w_rdata = 32'(cnt_q[i]);
`endif
        end
    end

    assign rd_data_d = w_is_load ? w_rdata : rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else begin
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= w_is_load;
            cnt_q      <= cnt_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_perf.sv
// ============================================================================
// Module      : tb_mmio_uart_perf
// Description : Self-checking bench; queue-based reference model plus directed
//               literal checks on a 32-bit-counter and a 4-bit-counter instance.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_perf;

    localparam int DEPTH = 8;
    localparam int NC    = 4;
`ifdef MMIO_LEGACY_MAP_EN
    localparam bit LEG = 1'b1;
`else
    localparam bit LEG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [11:0]   req_addr = 12'h0;
    logic [7:0]    req_wdata = 8'h0;
    logic          tx_ready = 1'b0;
    logic [7:0]    rx_data = 8'h0;
    logic          rx_valid = 1'b0;
    logic [NC-1:0] cnt_event = '0;

    logic [31:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;
    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_tx_valid, b_tx_valid;
    logic        a_rx_ready, b_rx_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_uart_perf #(.FIFO_AW(3), .NUM_CNT(NC), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(a_rx_ready), .cnt_event(cnt_event)
    );

    mmio_uart_perf #(.FIFO_AW(3), .NUM_CNT(NC), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(b_rx_ready), .cnt_event(cnt_event)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    int unsigned cnt [NC];
    bit          ovf;
    bit          exp_rv;
    logic [31:0] exp_ra, exp_rb;

    logic [11:0] m_addr;
    bit          m_ld, m_st, m_txfull, m_rxfull, m_clr;

    function automatic logic [31:0] mread(input logic [11:0] a, input logic [31:0] mask);
        logic [31:0] r;
        int          idx;
        r   = 32'h0;
        idx = -1;
        if (a == 12'h000)
            r = {29'h0, ovf, (rxq.size() != 0), (txq.size() != DEPTH)};
        else if (a == 12'h004)
            r = (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'h0;
        else if (a == 12'h00C)
            r = {16'h0, 8'(rxq.size()), 8'(txq.size())};
        else if (int'(a) >= 256 && int'(a) < 256 + 4 * NC)
            idx = (int'(a) - 256) / 4;
        else if (LEG) begin
            case (a)
                12'h010: idx = 0;
                12'h014: idx = 1;
                12'h01C: idx = 2;
                12'h020: idx = 3;
                default: idx = -1;
            endcase
        end
        if (idx >= 0 && idx < NC) r = cnt[idx] & mask;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            txq.delete();
            rxq.delete();
            for (int i = 0; i < NC; i++) cnt[i] = 0;
            ovf    = 1'b0;
            exp_rv = 1'b0;
        end else begin
            m_addr = {req_addr[11:2], 2'b00};
            m_ld   = req_valid && !req_we;
            m_st   = req_valid && req_we;
            exp_rv = m_ld;
            if (m_ld) begin
                exp_ra = mread(m_addr, 32'hFFFF_FFFF);
                exp_rb = mread(m_addr, 32'h0000_000F);
            end
            m_txfull = (txq.size() == DEPTH);
            m_rxfull = (rxq.size() == DEPTH);
            if (m_ld && m_addr == 12'h000) ovf = 1'b0;
            if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
            if (m_st && m_addr == 12'h008) begin
                if (m_txfull) ovf = 1'b1;
                else          txq.push_back(req_wdata);
            end
            if (m_ld && m_addr == 12'h004 && rxq.size() > 0) void'(rxq.pop_front());
            if (rx_valid && !m_rxfull) rxq.push_back(rx_data);
            m_clr = m_st && (m_addr == 12'h010 || (LEG && m_addr == 12'h018));
            for (int i = 0; i < NC; i++)
                cnt[i] = m_clr ? 0 : cnt[i] + int'(cnt_event[i]);
        end
        #1;
        chk("rd_valid_a", {31'h0, a_rd_valid}, {31'h0, exp_rv});
        chk("rd_valid_b", {31'h0, b_rd_valid}, {31'h0, exp_rv});
        if (exp_rv) begin
            chk("rd_data_a", a_rd_data, exp_ra);
            chk("rd_data_b", b_rd_data, exp_rb);
        end
        chk("tx_valid_a", {31'h0, a_tx_valid}, {31'h0, (txq.size() > 0)});
        chk("tx_valid_b", {31'h0, b_tx_valid}, {31'h0, (txq.size() > 0)});
        if (txq.size() > 0) begin
            chk("tx_data_a", {24'h0, a_tx_data}, {24'h0, txq[0]});
            chk("tx_data_b", {24'h0, b_tx_data}, {24'h0, txq[0]});
        end
        chk("rx_ready_a", {31'h0, a_rx_ready}, {31'h0, (rst_n && rxq.size() < DEPTH)});
        chk("rx_ready_b", {31'h0, b_rx_ready}, {31'h0, (rst_n && rxq.size() < DEPTH)});
    end

    // ---------------- stimulus (tasks start and end on a falling edge) ----------------
    task automatic do_store(input logic [11:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_load(input logic [11:0] a, output logic [31:0] da, output logic [31:0] db);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        da = a_rd_data;
        db = b_rd_data;
    endtask

    task automatic rx_send(input logic [7:0] b);
        int t;
        t = 0;
        rx_valid = 1'b1; rx_data = b;
        while (!a_rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("rx_send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", {31'h0, a_rd_valid}, 32'h0);
        chk("rst_rd_data",  a_rd_data, 32'h0);
        chk("rst_tx_valid", {31'h0, a_tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, a_rx_ready}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(12'h000, ra, rb);
        chk("status_after_reset", ra, 32'h1);

        // TX: nine stores into an eight-deep FIFO, uart stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) do_store(12'h008, 8'(8'hA0 + i));
        do_load(12'h00C, ra, rb);
        chk("tx_level_full", ra, 32'h8);
        chk("tx_head", {24'h0, a_tx_data}, 32'hA0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        do_load(12'h000, ra, rb);
        chk("status_ovf", ra, 32'h5);
        do_load(12'h000, ra, rb);
        chk("status_ovf_cleared", ra, 32'h1);
        do_load(12'h00C, ra, rb);
        chk("tx_level_7", ra, 32'h7);
        tx_ready = 1'b1;
        repeat (9) @(negedge clk);
        chk("tx_drained", {31'h0, a_tx_valid}, 32'h0);

        // RX basic
        rx_send(8'h41);
        rx_send(8'h42);
        do_load(12'h004, ra, rb);
        chk("rx_first", ra, 32'h41);
        do_load(12'h004, ra, rb);
        chk("rx_second", ra, 32'h42);
        do_load(12'h004, ra, rb);
        chk("rx_empty_load", ra, 32'h0);
        do_load(12'h00C, ra, rb);
        chk("levels_empty", ra, 32'h0);

        // RX full with uart backpressure
        for (int i = 0; i < 8; i++) rx_send(8'(8'h10 + i));
        do_load(12'h00C, ra, rb);
        chk("rx_level_full", ra, 32'h800);
        rx_valid = 1'b1; rx_data = 8'h18;
        repeat (3) @(negedge clk);
        chk("rx_ready_full", {31'h0, a_rx_ready}, 32'h0);
        do_load(12'h004, ra, rb);
        chk("rx_pop_full", ra, 32'h10);
        chk("rx_ready_after_pop", {31'h0, a_rx_ready}, 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("rx_ready_refull", {31'h0, a_rx_ready}, 32'h0);
        do_load(12'h00C, ra, rb);
        chk("rx_level_still_8", ra, 32'h800);
        for (int i = 0; i < 8; i++) begin
            do_load(12'h004, ra, rb);
            chk("rx_drain", ra, 32'(8'h11 + i));
        end

        // Counters
        do_store(12'h010, 8'h0);
        cnt_event = 4'b0101;
        repeat (10) @(negedge clk);
        cnt_event = 4'b0000;
        do_load(12'h100, ra, rb);
        chk("cnt0_10_a", ra, 32'd10);
        chk("cnt0_10_b", rb, 32'd10);
        do_load(12'h108, ra, rb);
        chk("cnt2_10", ra, 32'd10);
        cnt_event = 4'b0001;
        do_store(12'h010, 8'h0);
        cnt_event = 4'b0000;
        do_load(12'h100, ra, rb);
        chk("cnt0_clear_wins", ra, 32'd0);

        cnt_event = 4'b0010;
        repeat (17) @(negedge clk);
        cnt_event = 4'b0000;
        do_load(12'h104, ra, rb);
        chk("cnt1_17_a", ra, 32'd17);
        chk("cnt1_wrap_b", rb, 32'd1);

        cnt_event = 4'b0010;
        do_load(12'h104, ra, rb);
        cnt_event = 4'b0000;
        chk("cnt1_pre_incr", ra, 32'd17);
        do_load(12'h104, ra, rb);
        chk("cnt1_post_incr", ra, 32'd18);
        chk("cnt1_post_incr_b", rb, 32'd2);

        // Legacy aliases (or unmapped zeros)
        do_load(12'h014, ra, rb);
        chk("legacy_cnt1", ra, LEG ? 32'd18 : 32'd0);
        do_load(12'h010, ra, rb);
        chk("legacy_cnt0", ra, 32'd0);
        do_load(12'h01C, ra, rb);
        do_load(12'h020, ra, rb);
        do_load(12'h018, ra, rb);
        do_load(12'h110, ra, rb);
        chk("cnt_out_of_range", ra, 32'd0);
        do_load(12'h200, ra, rb);
        do_store(12'h018, 8'h0);
        do_load(12'h104, ra, rb);
        chk("legacy_clr", ra, LEG ? 32'd0 : 32'd18);

        // Reset in the middle of traffic
        tx_ready = 1'b0;
        cnt_event = 4'b1111;
        for (int i = 0; i < 3; i++) do_store(12'h008, 8'(8'h60 + i));
        rx_send(8'h55);
        rst_n = 1'b0;
        #1;
        chk("midreset_tx_valid", {31'h0, a_tx_valid}, 32'h0);
        chk("midreset_rx_ready", {31'h0, a_rx_ready}, 32'h0);
        cnt_event = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(12'h00C, ra, rb);
        chk("midreset_levels", ra, 32'h0);
        do_load(12'h10C, ra, rb);
        chk("midreset_cnt3", ra, 32'h0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
